// File: rtl/pmem_burst_responder.sv
// pmem_burst_responder: line-granular memory model answering read/write line
// requests with a fixed-latency, four-beat 64-bit burst.
module pmem_burst_responder #(
  parameter int unsigned LATENCY       = 4,
  parameter int unsigned LINE_IDX_BITS = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] pmem_address,
  input  logic        pmem_read,
  input  logic        pmem_write,
  input  logic [63:0] pmem_wdata,
  output logic [63:0] pmem_rdata,
  output logic        pmem_resp,
  output logic        proto_err
);

  localparam int unsigned LINES   = 1 << LINE_IDX_BITS;
  localparam int unsigned BEATS   = 4;
  localparam int unsigned MEM_AW  = LINE_IDX_BITS + 2;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned BEAT_W  = 2;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_BURST = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]               state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [BEAT_W-1:0]        beat_q, beat_d;
  logic [LINE_IDX_BITS-1:0] idx_q, idx_d;
  logic                     wr_q, wr_d;
  logic                     resp_q, resp_d;
  logic [63:0]              rdata_q, rdata_d;
  logic                     perr_q, perr_d;
  logic                     mem_we_c;

  logic [63:0] mem_q [BEATS*LINES];

  // Upper address bits alias onto the stored lines and are intentionally unused.
  logic unused_addr_bits;
  assign unused_addr_bits = ^pmem_address[31:LINE_IDX_BITS+5];

  // Next-state, datapath and storage write-enable decode.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    beat_d   = beat_q;
    idx_d    = idx_q;
    wr_d     = wr_q;
    resp_d   = resp_q;
    rdata_d  = rdata_q;
    perr_d   = 1'b0;
    mem_we_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pmem_read || pmem_write) begin
          idx_d   = pmem_address[LINE_IDX_BITS+4:5];
          wr_d    = pmem_write && !pmem_read;
          perr_d  = (pmem_read && pmem_write) || (|pmem_address[4:0]);
          cnt_d   = CNT_W'(LATENCY - 1);
          beat_d  = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_BURST;
          resp_d  = 1'b1;
          rdata_d = wr_q ? 64'd0 : mem_q[{idx_q, 2'd0}];
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_BURST: begin
        // Write beats commit at the edge that ends their resp cycle.
        mem_we_c = wr_q;
        if (beat_q == 2'd3) begin
          resp_d  = 1'b0;
          rdata_d = 64'd0;
          state_d = S_DONE;
        end else begin
          beat_d  = beat_q + 2'd1;
          rdata_d = wr_q ? 64'd0 : mem_q[{idx_q, beat_q + 2'd1}];
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control and output registers; reset aborts any burst in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      beat_q  <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      resp_q  <= 1'b0;
      rdata_q <= 64'd0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
      resp_q  <= resp_d;
      rdata_q <= rdata_d;
      perr_q  <= perr_d;
    end
  end

  // Line storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem_q[MEM_AW'({idx_q, beat_q})] <= pmem_wdata;
    end
  end

  assign pmem_resp  = resp_q;
  assign pmem_rdata = rdata_q;
  assign proto_err  = perr_q;

endmodule

// File: tb/tb_pmem_burst_responder.sv
// Directed bench for pmem_burst_responder (LATENCY=4 and LATENCY=1 instances).
module tb_pmem_burst_responder;

  logic        clk;
  logic        reset_n;

  logic [31:0] a_addr;
  logic        a_read, a_write;
  logic [63:0] a_wdata, a_rdata;
  logic        a_resp, a_perr;

  logic [31:0] b_addr;
  logic        b_read, b_write;
  logic [63:0] b_wdata, b_rdata;
  logic        b_resp, b_perr;

  int n_cmp;
  int n_bad;

  pmem_burst_responder #(.LATENCY(4), .LINE_IDX_BITS(8)) u_dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .pmem_address (a_addr),
    .pmem_read    (a_read),
    .pmem_write   (a_write),
    .pmem_wdata   (a_wdata),
    .pmem_rdata   (a_rdata),
    .pmem_resp    (a_resp),
    .proto_err    (a_perr)
  );

  pmem_burst_responder #(.LATENCY(1), .LINE_IDX_BITS(8)) u_dut_l1 (
    .clk          (clk),
    .reset_n      (reset_n),
    .pmem_address (b_addr),
    .pmem_read    (b_read),
    .pmem_write   (b_write),
    .pmem_wdata   (b_wdata),
    .pmem_rdata   (b_rdata),
    .pmem_resp    (b_resp),
    .proto_err    (b_perr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one transaction on the LATENCY=4 instance starting from IDLE and
  // record what came back. Request goes low from beat drop_at onward.
  task automatic do_txn(input logic [31:0] addr, input logic rd, input logic wr,
                        input logic [255:0] wline, input int drop_at,
                        output logic [255:0] rline, output int first_edge,
                        output int n_resp, output int n_perr, output int n_nz);
    int k;
    rline = '0; first_edge = -1; n_resp = 0; n_perr = 0; n_nz = 0;
    a_addr = addr; a_read = rd; a_write = wr; a_wdata = wline[63:0];
    for (int e = 0; e < 16; e++) begin
      step();
      if (a_perr) n_perr++;
      if (a_resp) begin
        if (first_edge < 0) first_edge = e;
        k = n_resp;
        if (k < 4) begin
          rline[64*k +: 64] = a_rdata;
          a_wdata = wline[64*k +: 64];
          if (k >= drop_at) begin a_read = 1'b0; a_write = 1'b0; end
        end
        n_resp++;
      end else begin
        if (a_rdata !== 64'd0) n_nz++;
        if (n_resp >= 4) begin
          a_read = 1'b0; a_write = 1'b0;
          step();
          if (a_perr) n_perr++;
          break;
        end
      end
    end
    a_read = 1'b0; a_write = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    n_cmp++; if (a_resp !== 1'b0) begin n_bad++; $display("FAIL reset_resp: got %b expected 0", a_resp); end
    n_cmp++; if (a_rdata !== 64'd0) begin n_bad++; $display("FAIL reset_rdata: got %h expected 0", a_rdata); end
    n_cmp++; if (a_perr !== 1'b0) begin n_bad++; $display("FAIL reset_perr: got %b expected 0", a_perr); end
    n_cmp++; if (b_resp !== 1'b0) begin n_bad++; $display("FAIL reset_resp_l1: got %b expected 0", b_resp); end
    step(); step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_write_read();
    logic [255:0] wl, rl;
    int fe, nr, np, nz;
    wl = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
          64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    do_txn(32'h100, 1'b0, 1'b1, wl, 4, rl, fe, nr, np, nz);
    n_cmp++; if (fe !== 4) begin n_bad++; $display("FAIL wr_first_resp_edge: got %0d expected 4", fe); end
    n_cmp++; if (nr !== 4) begin n_bad++; $display("FAIL wr_resp_cycles: got %0d expected 4", nr); end
    n_cmp++; if (np !== 0) begin n_bad++; $display("FAIL wr_perr: got %0d expected 0", np); end
    do_txn(32'h100, 1'b1, 1'b0, 256'd0, 4, rl, fe, nr, np, nz);
    n_cmp++; if (fe !== 4) begin n_bad++; $display("FAIL rd_first_resp_edge: got %0d expected 4", fe); end
    n_cmp++; if (nr !== 4) begin n_bad++; $display("FAIL rd_resp_cycles: got %0d expected 4", nr); end
    n_cmp++; if (rl !== wl) begin n_bad++; $display("FAIL rd_line_0x100: got %h expected %h", rl, wl); end
    n_cmp++; if (nz !== 0) begin n_bad++; $display("FAIL rd_rdata_idle_zero: got %0d nonzero cycles expected 0", nz); end
  endtask

  task automatic test_both_high();
    logic [255:0] dl, rl;
    int fe, nr, np, nz;
    dl = {64'hD3D3_0000_0000_0003, 64'hD2D2_0000_0000_0002,
          64'hD1D1_0000_0000_0001, 64'hD0D0_0000_0000_0000};
    do_txn(32'h300, 1'b0, 1'b1, dl, 4, rl, fe, nr, np, nz);
    do_txn(32'h300, 1'b1, 1'b1, {4{64'hBAD0_BAD0_BAD0_BAD0}}, 4, rl, fe, nr, np, nz);
    n_cmp++; if (np !== 1) begin n_bad++; $display("FAIL both_perr_cycles: got %0d expected 1", np); end
    n_cmp++; if (rl !== dl) begin n_bad++; $display("FAIL both_read_data: got %h expected %h", rl, dl); end
    n_cmp++; if (nr !== 4) begin n_bad++; $display("FAIL both_resp_cycles: got %0d expected 4", nr); end
    do_txn(32'h300, 1'b1, 1'b0, 256'd0, 4, rl, fe, nr, np, nz);
    n_cmp++; if (rl !== dl) begin n_bad++; $display("FAIL both_storage_kept: got %h expected %h", rl, dl); end
  endtask

  task automatic test_reset_mid_burst();
    logic [255:0] al, bl, el, rl;
    int fe, nr, np, nz;
    al = {64'hA3, 64'hA2, 64'hA1, 64'hA0};
    bl = {64'hB3, 64'hB2, 64'hB1, 64'hB0};
    el = {64'hA3, 64'hA2, 64'hB1, 64'hB0};
    do_txn(32'h200, 1'b0, 1'b1, al, 4, rl, fe, nr, np, nz);
    a_addr = 32'h200; a_write = 1'b1; a_wdata = 64'hB0;
    step();                        // E0
    step(); step(); step(); step(); // E1..E4, beat 0 cycle
    n_cmp++; if (a_resp !== 1'b1) begin n_bad++; $display("FAIL rst_beat0_resp: got %b expected 1", a_resp); end
    step(); a_wdata = 64'hB1;      // beat 1 cycle
    step(); a_wdata = 64'hB2;      // beat 2 cycle
    n_cmp++; if (a_resp !== 1'b1) begin n_bad++; $display("FAIL rst_beat2_resp: got %b expected 1", a_resp); end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++; if (a_resp !== 1'b0) begin n_bad++; $display("FAIL rst_mid_resp: got %b expected 0", a_resp); end
    n_cmp++; if (a_rdata !== 64'd0) begin n_bad++; $display("FAIL rst_mid_rdata: got %h expected 0", a_rdata); end
    a_write = 1'b0;
    step(); step();
    reset_n = 1'b1;
    step();
    do_txn(32'h200, 1'b1, 1'b0, 256'd0, 4, rl, fe, nr, np, nz);
    n_cmp++; if (rl !== el) begin n_bad++; $display("FAIL rst_partial_line: got %h expected %h", rl, el); end
  endtask

  task automatic test_misaligned();
    logic [255:0] cl, rl;
    int fe, nr, np, nz;
    cl = {64'hC3C3_C3C3_C3C3_C3C3, 64'hC2C2_C2C2_C2C2_C2C2,
          64'hC1C1_C1C1_C1C1_C1C1, 64'hC0C0_C0C0_C0C0_C0C0};
    do_txn(32'h2004, 1'b0, 1'b1, cl, 4, rl, fe, nr, np, nz);
    n_cmp++; if (np !== 1) begin n_bad++; $display("FAIL misalign_perr: got %0d expected 1", np); end
    do_txn(32'h0000, 1'b1, 1'b0, 256'd0, 4, rl, fe, nr, np, nz);
    n_cmp++; if (rl !== cl) begin n_bad++; $display("FAIL alias_line_0: got %h expected %h", rl, cl); end
    n_cmp++; if (np !== 0) begin n_bad++; $display("FAIL aligned_perr: got %0d expected 0", np); end
    do_txn(32'h2000, 1'b1, 1'b0, 256'd0, 4, rl, fe, nr, np, nz);
    n_cmp++; if (rl !== cl) begin n_bad++; $display("FAIL alias_line_2000: got %h expected %h", rl, cl); end
  endtask

  task automatic test_drop_request();
    logic [255:0] wl, rl;
    int fe, nr, np, nz;
    wl = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
          64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    do_txn(32'h100, 1'b1, 1'b0, 256'd0, 2, rl, fe, nr, np, nz);
    n_cmp++; if (nr !== 4) begin n_bad++; $display("FAIL drop_resp_cycles: got %0d expected 4", nr); end
    n_cmp++; if (rl !== wl) begin n_bad++; $display("FAIL drop_read_data: got %h expected %h", rl, wl); end
    step();
    n_cmp++; if (a_resp !== 1'b0) begin n_bad++; $display("FAIL drop_idle_resp: got %b expected 0", a_resp); end
  endtask

  task automatic test_latency1();
    logic exp;
    b_addr = 32'h40; b_read = 1'b1;
    step(); // E0
    for (int n = 1; n <= 8; n++) begin
      step();
      exp = (n <= 4) || (n == 8);
      n_cmp++;
      if (b_resp !== exp) begin n_bad++; $display("FAIL l1_resp_after_E%0d: got %b expected %b", n, b_resp, exp); end
    end
    b_read = 1'b0;
    for (int n = 0; n < 8; n++) step();
    n_cmp++; if (b_resp !== 1'b0) begin n_bad++; $display("FAIL l1_final_resp: got %b expected 0", b_resp); end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    a_addr = '0; a_read = 1'b0; a_write = 1'b0; a_wdata = '0;
    b_addr = '0; b_read = 1'b0; b_write = 1'b0; b_wdata = '0;
    reset_n = 1'b1;
    test_reset();
    test_write_read();
    test_both_high();
    test_reset_mid_burst();
    test_misaligned();
    test_drop_request();
    test_latency1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pmem_burst_responder.md
PMEM_BURST_RESPONDER -- requirements
Module: pmem_burst_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 4, meaning cycles from request acceptance to first pmem_resp beat (legal 1..15).
REQ-002 SHALL have parameter LINE_IDX_BITS, default 8, meaning log2 of the number of 256-bit lines stored (default 256 lines).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port pmem_address  input  32  line address from the requester; bits [4:0] ignored.
REQ-006 SHALL have port pmem_read  input  1  read-line request, held by the requester until the last beat.
REQ-007 SHALL have port pmem_write  input  1  write-line request, held by the requester until the last beat.
REQ-008 SHALL have port pmem_wdata  input  64  write beat presented by the requester.
REQ-009 SHALL have port pmem_rdata  output  64  read beat; 0 whenever pmem_resp is low.
REQ-010 SHALL have port pmem_resp  output  1  beat-valid strobe, high exactly 4 consecutive cycles per transaction.
REQ-011 SHALL have port proto_err  output  1  single-cycle pulse on a protocol violation.

Function
REQ-012 SHALL implement states IDLE, WAIT, BURST, DONE; all outputs registered.
REQ-013 In IDLE, SHALL accept a request at the edge where pmem_read or pmem_write is high, capture the index pmem_address[LINE_IDX_BITS+4:5] and the op, load the latency counter, and go to WAIT; upper address bits alias.
REQ-014 Given acceptance edge E0, SHALL hold pmem_resp high after edges E(LATENCY)..E(LATENCY+3) and low after E(LATENCY+4).
REQ-015 Read: SHALL drive beat k = line bits [64k+63:64k] on pmem_rdata during the k-th resp cycle (k=0..3, low beat first).
REQ-016 Write: SHALL sample pmem_wdata at the edge ending the k-th resp cycle and commit it immediately to beat k of the captured line.
REQ-017 SHALL move BURST->DONE after beat 3, spend exactly one cycle in DONE ignoring all requests, then return to IDLE; the earliest next acceptance is E(LATENCY+6).
REQ-018 SHALL ignore pmem_address, pmem_read and pmem_write changes after acceptance; a burst always completes all 4 beats even if the request is dropped early.
REQ-019 pmem_read and pmem_write both high at acceptance SHALL be treated as a read and SHALL pulse proto_err for one cycle.
REQ-020 A request still high when DONE->IDLE SHALL be treated as a new transaction (no filtering).
REQ-021 Nonzero pmem_address[4:0] at acceptance SHALL pulse proto_err; the access proceeds line-aligned.
REQ-022 A read and a write to the same line in consecutive transactions SHALL return the newly written data (no stale buffering).

Reset
REQ-023 reset_n low SHALL immediately force IDLE, pmem_resp=0, pmem_rdata=0, proto_err=0 and clear the counter, regardless of the current edge.
REQ-024 Reset mid-burst SHALL abort the transaction; write beats already committed stay in storage and uncommitted beats are unchanged.
REQ-025 Line storage SHALL NOT be cleared by reset; contents are undefined until written.

Verification
REQ-026 Write line 0x100 with beats 0x11..11, 0x22..22, 0x33..33, 0x44..44, then read 0x100 -> same 4 beats in order; resp first high after E4 (LATENCY=4).
REQ-027 Read with LATENCY=1 -> resp high after E1..E4, low after E5; next request held high from E5 accepted at E7.
REQ-028 pmem_read and pmem_write both high at acceptance -> proto_err one cycle, read burst returned, storage unchanged.
REQ-029 Write to 0x200, reset_n asserted during beat 2 -> resp/rdata immediately 0; later read of 0x200 shows new beats 0-1 and old beats 2-3.
REQ-030 Address 0x2004 (LINE_IDX_BITS=8) -> proto_err pulses; data aliases line 0x2000 and 0x0000 (index 0).
REQ-031 Requester drops pmem_read after beat 1 -> resp still high for beats 2-3, then DONE, then IDLE.
